jedro_1_shift_cmp_unit: RTL and testbench
=========================================

# jedro_1_shift_cmp_unit

Registered shift-and-compare execution unit for the jedro_1 RV32I core. It computes SLL, SRL, SRA and SLT (and optionally SLTU) on two 32-bit operands. The core is built from a 5-stage left barrel shifter, a 5-stage right barrel shifter with arithmetic fill, and a signed less-than comparator. The result is captured in an output register one cycle after issue.

## Interface
- `DATA_WIDTH`, default 32: operand/result width; only 32 is supported because the shifters are fixed 5-stage.
- `clk_i`, input, 1: clock; all state updates on the rising edge.
- `rst_i`, input, 1: one clock; reset is synchronous and active-high.
- `valid_i`, input, 1: operation issue strobe.
- `op_i`, input, 3: operation select.
  - 3'b000 SLL
  - 3'b001 SRL
  - 3'b101 SRA
  - 3'b010 SLT
  - 3'b011 SLTU
  - all other codes reserved
- `opa_i`, input, 32: operand A, the value shifted or compared.
- `opb_i`, input, 32: operand B; shift amount in bits [4:0], or compare right-hand side.
- `res_o`, output, 32: registered result.
- `valid_o`, output, 1: `res_o` was updated by the previous cycle's issue.

## Operation
- **Left shifter:** five cascaded mux stages (shift by 1, 2, 4, 8, 16), each enabled by one bit of `opb_i[4:0]`; zero fill.
- **Right shifter:** same five-stage structure. The fill bit is `opa_i[31]` when `op_i[2]`=1 (SRA), else 0 (SRL). `op_i[2]` is the arithmetic select.
- **Shift amount:** `opb_i[31:5]` is ignored for all shifts. Shift by 0 returns `opa_i` unchanged. Shift by 31 leaves one significant bit.
- **SLT:** result is 32'h1 if `opa_i` < `opb_i` as two's-complement numbers, else 32'h0.
  - Equal operands give 0.
  - Mixed signs are decided by the sign bits.
  - 32'h80000000 is the minimum value.
- **SLTU:** unsigned less-than, 32'h1 or 32'h0. Present only with the configuration macro (see Configuration).
- **Reserved op codes:** combinational result is 32'h0. The registered result becomes 32'h0 and `valid_o` is asserted normally; no error flag.
- **Result mux:** purely combinational from `op_i`/`opa_i`/`opb_i`. Only the output is registered.

## Timing
- **Reset:** `rst_i` high at a rising edge forces `res_o`=32'h0 and `valid_o`=0. This overrides a simultaneous `valid_i`.
  - Reset mid-operation discards the in-flight result.
  - The first valid issue after reset deassertion produces `valid_o` one cycle later.
- **Latency:** exactly 1 cycle. A cycle with `valid_i`=1 at edge N gives `res_o`=f(`op_i`, `opa_i`, `opb_i`) and `valid_o`=1 after edge N.
- **Idle cycles:** with `valid_i`=0 at an edge, `valid_o`←0 and `res_o` holds its previous value.
- **Throughput:** one operation per cycle. Back-to-back issues produce back-to-back `valid_o` pulses with no bubbles.
- **Flow control:** no stall or backpressure. Downstream must consume `res_o` in the cycle `valid_o` is high.
- **Inputs:** sampled only at the rising edge. No input registering, so combinational input-to-register path depth is 5 mux levels plus the compare.

## Configuration
- Macro `JEDRO_1_SHCMP_SLTU_EN`.
- **Defined:** the unsigned less-than comparator is instantiated and op 3'b011 returns the unsigned compare (32'h1 or 32'h0).
- **Undefined:** no unsigned comparator logic is built and op 3'b011 is treated as reserved (result 32'h0).
- All other operations are identical in both builds.

## Test plan
- **Reset:** assert `rst_i` with `valid_i`=1, op SLL, A=32'hFFFFFFFF, B=1 → after the edge `res_o`=0, `valid_o`=0. Deassert, issue the same op → next cycle `res_o`=32'hFFFFFFFE, `valid_o`=1.
- **Shifts:** A=32'h80000001.
  - SLL B=31 → 32'h80000000
  - SRL B=31 → 32'h00000001
  - SRA B=31 → 32'hFFFFFFFF
  - SRA B=32'h00000020 (amount 0) → 32'h80000001
  - SRL A=32'h12345678 B=4 → 32'h01234567
- **SLT:**
  - A=32'hFFFFFFFF, B=1 → 1
  - A=1, B=32'hFFFFFFFF → 0
  - A=B=32'h7FFFFFFF → 0
  - A=32'h80000000, B=32'h7FFFFFFF → 1
- **SLTU:** A=1, B=32'hFFFFFFFF → 1 when the macro is defined, 0 when it is undefined.
  - Reserved op 3'b110 → 0 with `valid_o`=1.
- **Throughput/hold:**
  - Issue 4 consecutive ops → 4 consecutive `valid_o`.
  - Then `valid_i`=0 → `valid_o`=0 and `res_o` holds the 4th result.
- **Randomized:** 10k random ops/operands checked against a reference model, including shift amounts 0/31 and sign-boundary operands.

Source files
------------

// File: rtl/jedro_1_shift_cmp_unit.sv
// -----------------------------------------------------------------------------
// jedro_1_shift_cmp_unit
//
// Registered shift-and-compare execution unit for the jedro_1 RV32I core.
// Computes SLL, SRL, SRA and SLT (plus SLTU when enabled) on two 32-bit
// operands. The result mux is purely combinational. Only the result and
// its valid strobe are registered, so the latency is exactly one cycle.
//
// Configuration macro:
//   JEDRO_1_SHCMP_SLTU_EN  - when defined, builds the unsigned comparator and
//                            op 3'b011 returns SLTU. When undefined, 3'b011 is
//                            a reserved code and returns 32'h0.
//
// Parameters:
//   DATA_WIDTH   operand/result width. Only 32 is supported, because the
//                shifters are fixed at five stages (shift amount opb_i[4:0]).
//
// Ports:
//   clk_i    in   1   clock, rising-edge active
//   rst_i    in   1   synchronous active-high reset
//   valid_i  in   1   operation issue strobe
//   op_i     in   3   000 SLL, 001 SRL, 101 SRA, 010 SLT, 011 SLTU, rest reserved
//   opa_i    in   32  operand A (value shifted / compare left-hand side)
//   opb_i    in   32  operand B (shift amount in [4:0] / compare right-hand side)
//   res_o    out  32  registered result
//   valid_o  out  1   res_o was updated by the previous cycle's issue
// -----------------------------------------------------------------------------
module jedro_1_shift_cmp_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic [2:0]            op_i,
  input  logic [DATA_WIDTH-1:0] opa_i,
  input  logic [DATA_WIDTH-1:0] opb_i,
  output logic [DATA_WIDTH-1:0] res_o,
  output logic                  valid_o
);

  localparam int NUM_STAGES = 5;

  localparam logic [2:0] OP_SLL  = 3'b000;
  localparam logic [2:0] OP_SRL  = 3'b001;
  localparam logic [2:0] OP_SRA  = 3'b101;
  localparam logic [2:0] OP_SLT  = 3'b010;
  localparam logic [2:0] OP_SLTU = 3'b011;

  // ---------------------------------------------------------------------------
  // Barrel shifters: stage gi shifts by 2**gi when opb_i[gi] is set.
  // Stage 0 of each array is the unshifted operand.
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] sll_stage [NUM_STAGES+1];
  logic [DATA_WIDTH-1:0] sr_stage  [NUM_STAGES+1];
  logic                  sr_fill;

  // op_i[2] distinguishes SRA from SRL; the fill bit is the sign of A for SRA.
  assign sr_fill     = op_i[2] & opa_i[DATA_WIDTH-1];
  assign sll_stage[0] = opa_i;
  assign sr_stage[0]  = opa_i;

  generate
    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_shift_stage
      localparam int SH = 1 << gi;

      assign sll_stage[gi+1] = opb_i[gi]
                             ? {sll_stage[gi][DATA_WIDTH-1-SH:0], {SH{1'b0}}}
                             : sll_stage[gi];

      assign sr_stage[gi+1]  = opb_i[gi]
                             ? {{SH{sr_fill}}, sr_stage[gi][DATA_WIDTH-1:SH]}
                             : sr_stage[gi];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Signed less-than: differing signs are decided by A's sign bit alone;
  // equal signs reduce to an unsigned compare of the remaining bits.
  // ---------------------------------------------------------------------------
  logic slt_bit;
  logic sign_differs;

  assign sign_differs = opa_i[DATA_WIDTH-1] ^ opb_i[DATA_WIDTH-1];
  assign slt_bit      = sign_differs ? opa_i[DATA_WIDTH-1]
                                     : (opa_i[DATA_WIDTH-2:0] < opb_i[DATA_WIDTH-2:0]);

`ifdef JEDRO_1_SHCMP_SLTU_EN
  logic sltu_bit;
  assign sltu_bit = (opa_i < opb_i);
`endif

  // ---------------------------------------------------------------------------
  // Result mux (combinational)
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] res_next;
  logic                  valid_next;

  always_comb begin
    res_next = '0;
    unique case (op_i)
      OP_SLL:  res_next = sll_stage[NUM_STAGES];
      OP_SRL,
      OP_SRA:  res_next = sr_stage[NUM_STAGES];
      OP_SLT:  res_next = {{(DATA_WIDTH-1){1'b0}}, slt_bit};
`ifdef JEDRO_1_SHCMP_SLTU_EN
      OP_SLTU: res_next = {{(DATA_WIDTH-1){1'b0}}, sltu_bit};
`else
      OP_SLTU: res_next = '0;
`endif
      default: res_next = '0;
    endcase
  end

  assign valid_next = valid_i;

  // ---------------------------------------------------------------------------
  // Output register. The result holds across idle cycles; valid is a
  // single-cycle strobe that follows the issue by one edge.
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] res_reg;
  logic                  valid_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      res_reg   <= '0;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= valid_next;
      if (valid_i) begin
        res_reg <= res_next;
      end
    end
  end

  assign res_o   = res_reg;
  assign valid_o = valid_reg;

endmodule

// File: tb/tb_jedro_1_shift_cmp_unit.sv
module tb_jedro_1_shift_cmp_unit;

  logic        clk_i;
  logic        rst_i;
  logic        valid_i;
  logic [2:0]  op_i;
  logic [31:0] opa_i;
  logic [31:0] opb_i;
  logic [31:0] res_o;
  logic        valid_o;

  int errors = 0;
  int checks = 0;

  logic [31:0] sb_q[$];
  logic [31:0] last_res;

  jedro_1_shift_cmp_unit #(.DATA_WIDTH(32)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .op_i    (op_i),
    .opa_i   (opa_i),
    .opb_i   (opb_i),
    .res_o   (res_o),
    .valid_o (valid_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  // Reference behaviour written with plain language operators.
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      3'b000: return a << sh;
      3'b001: return a >> sh;
      3'b101: return $unsigned($signed(a) >>> sh);
      3'b010: return ($signed(a) < $signed(b)) ? 32'h1 : 32'h0;
`ifdef JEDRO_1_SHCMP_SLTU_EN
      3'b011: return (a < b) ? 32'h1 : 32'h0;
`endif
      default: return 32'h0;
    endcase
  endfunction

  // One clock cycle: drive at negedge, push expectation, sample 1 time unit
  // after the rising edge and pop/compare when the DUT reports a result.
  task automatic step(input string tag, input logic r, input logic v, input logic [2:0] op,
                      input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp;
    @(negedge clk_i);
    rst_i   = r;
    valid_i = v;
    op_i    = op;
    opa_i   = a;
    opb_i   = b;
    if (r) sb_q.delete();
    else if (v) sb_q.push_back(ref_model(op, a, b));
    @(posedge clk_i);
    #1;
    check({tag, "_valid"}, {31'b0, valid_o}, {31'b0, (v && !r)});
    if (r) begin
      check({tag, "_rst_res"}, res_o, 32'h0);
      last_res = 32'h0;
    end else if (valid_o) begin
      if (sb_q.size() == 0) begin
        check({tag, "_sb_underflow"}, res_o, ~res_o);
      end else begin
        exp = sb_q.pop_front();
        check({tag, "_res"}, res_o, exp);
        last_res = exp;
      end
    end else begin
      check({tag, "_hold"}, res_o, last_res);
    end
  endtask

  function automatic logic [31:0] corner_val();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] a, b;
    logic [2:0]  op;
    logic        v, r;
    rst_i = 1'b1; valid_i = 1'b0; op_i = 3'b000; opa_i = '0; opb_i = '0;
    last_res = 32'h0;

    // Reset overrides a simultaneous issue.
    step("rst",  1'b1, 1'b1, 3'b000, 32'hFFFF_FFFF, 32'h1);
    step("rst2", 1'b1, 1'b0, 3'b000, 32'h0, 32'h0);
    step("sll1", 1'b0, 1'b1, 3'b000, 32'hFFFF_FFFF, 32'h1);

    // Shift boundaries.
    step("sll31", 1'b0, 1'b1, 3'b000, 32'h8000_0001, 32'd31);
    step("srl31", 1'b0, 1'b1, 3'b001, 32'h8000_0001, 32'd31);
    step("sra31", 1'b0, 1'b1, 3'b101, 32'h8000_0001, 32'd31);
    step("sra0",  1'b0, 1'b1, 3'b101, 32'h8000_0001, 32'h0000_0020);
    step("srl4",  1'b0, 1'b1, 3'b001, 32'h1234_5678, 32'd4);

    // Signed compare corners.
    step("slt_neg", 1'b0, 1'b1, 3'b010, 32'hFFFF_FFFF, 32'h1);
    step("slt_pos", 1'b0, 1'b1, 3'b010, 32'h1, 32'hFFFF_FFFF);
    step("slt_eq",  1'b0, 1'b1, 3'b010, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    step("slt_min", 1'b0, 1'b1, 3'b010, 32'h8000_0000, 32'h7FFF_FFFF);

    // SLTU (result depends on build) and a reserved code.
    step("sltu", 1'b0, 1'b1, 3'b011, 32'h1, 32'hFFFF_FFFF);
    step("rsvd", 1'b0, 1'b1, 3'b110, 32'hFFFF_FFFF, 32'h1);

    // Four back-to-back issues, then idle cycles hold the fourth result.
    step("b2b0", 1'b0, 1'b1, 3'b000, 32'h0000_00F0, 32'd4);
    step("b2b1", 1'b0, 1'b1, 3'b001, 32'hF000_0000, 32'd8);
    step("b2b2", 1'b0, 1'b1, 3'b101, 32'hF000_0000, 32'd8);
    step("b2b3", 1'b0, 1'b1, 3'b000, 32'h0000_0003, 32'd30);
    step("idle0", 1'b0, 1'b0, 3'b010, 32'h1, 32'h2);
    step("idle1", 1'b0, 1'b0, 3'b000, 32'hFFFF_FFFF, 32'h0);

    // Mid-stream reset, then recovery.
    step("mid_rst", 1'b1, 1'b1, 3'b000, 32'h1, 32'h1);
    step("post_rst", 1'b0, 1'b1, 3'b000, 32'h1, 32'h1);

    // Randomized traffic with corner operands and occasional idle/reset.
    for (int i = 0; i < 10000; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = corner_val();
      case ($urandom_range(0, 3))
        0: b = {$urandom, 5'd0} | 32'h0;
        1: b = ($urandom & 32'hFFFF_FFE0) | 32'd31;
        default: b = corner_val();
      endcase
      v = ($urandom_range(0, 9) != 0);
      r = ($urandom_range(0, 199) == 0);
      step("rand", r, v, op, a, b);
    end

    step("drain", 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    check("sb_empty", 32'(sb_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
